// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: widths, ALU function codes and FSM states.
// Optional build macro ALU_ARB_FIXED_PRIO_EN (used by alu_rr_arb2) selects fixed priority.
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_FUN_W = 4;

    localparam logic [ALU_FUN_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_FUN_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_FUN_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_FUN_W-1:0] ALU_XOR = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way grant logic. Default: round-robin with a one-bit preference pointer.
// With ALU_ARB_FIXED_PRIO_EN defined: req0 always wins ties and the pointer is removed.
module alu_rr_arb2
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic w_pick1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_pick1 = i_req1 & ~i_req0;
`else
    logic r_ptr;

    // r_ptr == 1 means requester 1 is preferred on a tie.
    assign w_pick1 = i_req1 & (~i_req0 | r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_en && (i_req0 || i_req1)) begin
            r_ptr <= ~w_pick1;
        end
    end
`endif

    assign o_gnt1 = i_en & w_pick1;
    assign o_gnt0 = i_en & i_req0 & ~w_pick1;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external execute-stage ALU between two requesters, registers the tagged result
// and owns the Y86 condition codes. Build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int FUN_W = ALU_FUN_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FUN_W-1:0] req0_fun,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_set_cc,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FUN_W-1:0] req1_fun,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_set_cc,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_of,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,

    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    arb_state_e       r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [FUN_W-1:0] r_alu_fun;
    logic             r_set_cc;
    logic             r_id;
    logic             r_of_tmp;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_err;
    logic             r_cc_zf;
    logic             r_cc_sf;
    logic             r_cc_of;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_fun_legal;
    logic             w_fun_arith;

    assign w_idle = (r_state == ST_IDLE);

    alu_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_idle),
        .i_req0 (req0_valid),
        .i_req1 (req1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // The latched function stays on alu_fun for the whole EXEC state, so decode from it.
    assign w_fun_legal = (r_alu_fun <= FUN_W'(ALU_XOR));
    assign w_fun_arith = (r_alu_fun == FUN_W'(ALU_ADD)) || (r_alu_fun == FUN_W'(ALU_SUB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_fun    <= '0;
            r_set_cc     <= 1'b0;
            r_id         <= 1'b0;
            r_of_tmp     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_cc_zf      <= 1'b1;
            r_cc_sf      <= 1'b0;
            r_cc_of      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_alu_a   <= w_gnt1 ? req1_a      : req0_a;
                        r_alu_b   <= w_gnt1 ? req1_b      : req0_b;
                        r_alu_fun <= w_gnt1 ? req1_fun    : req0_fun;
                        r_set_cc  <= w_gnt1 ? req1_set_cc : req0_set_cc;
                        r_id      <= w_gnt1;
                        r_state   <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (w_fun_legal) begin
                        r_rsp_result <= alu_y;
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                    end
                    // Logical ops never overflow, whatever the ALU reports.
                    r_of_tmp    <= w_fun_arith & alu_of;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                    r_alu_fun   <= '0;
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    if (r_set_cc && !r_rsp_err) begin
                        r_cc_zf <= (r_rsp_result == '0);
                        r_cc_sf <= r_rsp_result[WIDTH-1];
                        r_cc_of <= r_of_tmp;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_fun    = r_alu_fun;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;

    assign cc_zf      = r_cc_zf;
    assign cc_sf      = r_cc_sf;
    assign cc_of      = r_cc_of;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural model of the external ALU.
// Expected grant order follows ALU_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_alu_share_arbiter;

    localparam int W = 64;
    localparam int F = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [F-1:0] req0_fun = '0, req1_fun = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_set_cc = 1'b0, req1_set_cc = 1'b0;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic [F-1:0] alu_fun;
    logic         alu_of;
    logic         rsp_valid, rsp_id, rsp_err;
    logic [W-1:0] rsp_result;
    logic         cc_zf, cc_sf, cc_of;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
        .req0_a(req0_a), .req0_b(req0_b), .req0_set_cc(req0_set_cc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
        .req1_a(req1_a), .req1_b(req1_b), .req1_set_cc(req1_set_cc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_y(alu_y), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    // External ALU: result = b op a; illegal codes return junk that must never reach rsp_result.
    always_comb begin
        alu_y  = '1;
        alu_of = 1'b1;
        case (alu_fun)
            4'd0: begin
                alu_y  = alu_b + alu_a;
                alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_b[W-1]);
            end
            4'd1: begin
                alu_y  = alu_b - alu_a;
                alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_b[W-1]);
            end
            4'd2: begin alu_y = alu_b & alu_a; alu_of = 1'b0; end
            4'd3: begin alu_y = alu_b ^ alu_a; alu_of = 1'b0; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of_);
        check({tag, "_zf"}, W'(cc_zf), W'(zf));
        check({tag, "_sf"}, W'(cc_sf), W'(sf));
        check({tag, "_of"}, W'(cc_of), W'(of_));
    endtask

    // One op from a single requester; returns at N+3 (CC visible).
    task automatic do_op(input string tag, input bit id, input logic [F-1:0] fun,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit set_cc,
                         input logic [W-1:0] exp_res, input bit exp_err);
        bit got_rdy;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_fun = fun; req1_a = a; req1_b = b; req1_set_cc = set_cc;
        end else begin
            req0_valid = 1'b1; req0_fun = fun; req0_a = a; req0_b = b; req0_set_cc = set_cc;
        end
        got_rdy = 1'b0;
        for (int c = 0; c < 20 && !got_rdy; c++) begin
            @(negedge clk);
            got_rdy = id ? req1_ready : req0_ready;
        end
        check({tag, "_ready"}, W'(got_rdy), W'(1));
        check({tag, "_other_ready"}, W'(id ? req0_ready : req1_ready), W'(0));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        check({tag, "_exec_alu_a"}, alu_a, a);
        check({tag, "_exec_alu_fun"}, W'(alu_fun), W'(fun));
        check({tag, "_exec_rsp_valid"}, W'(rsp_valid), W'(0));
        @(negedge clk);
        check({tag, "_rsp_valid"}, W'(rsp_valid), W'(1));
        check({tag, "_rsp_id"}, W'(rsp_id), W'(id));
        check({tag, "_rsp_result"}, rsp_result, exp_res);
        check({tag, "_rsp_err"}, W'(rsp_err), W'(exp_err));
        check({tag, "_resp_alu_b"}, alu_b, '0);
        @(negedge clk);
        check({tag, "_rsp_drop"}, W'(rsp_valid), W'(0));
        check({tag, "_rsp_hold"}, rsp_result, exp_res);
        $display("op %s id=%0d fun=%0d a=%h b=%h -> result=%h err=%0d cc=%0d%0d%0d",
                 tag, id, fun, a, b, rsp_result, rsp_err, cc_zf, cc_sf, cc_of);
    endtask

    bit           exp_order[8];
    bit           grant_ids[$];
    bit           exp_id_q[$];
    logic [W-1:0] exp_res_q[$];

    initial begin
        int cnt0, cnt1, nresp, cyc;
        bit           e_id;
        logic [W-1:0] e_res;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready0", W'(req0_ready), W'(0));
        check("rst_ready1", W'(req1_ready), W'(0));
        check("rst_rsp_valid", W'(rsp_valid), W'(0));
        check("rst_rsp_result", rsp_result, '0);
        check("rst_alu_a", alu_a, '0);
        check_cc("rst", 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_op("add5_7", 1'b0, 4'd0, 64'd5, 64'd7, 1'b1, 64'd12, 1'b0);
        check_cc("add5_7", 1'b0, 1'b0, 1'b0);

        do_op("sub8_8", 1'b1, 4'd1, 64'd8, 64'd8, 1'b0, 64'd0, 1'b0);
        check_cc("sub8_8", 1'b0, 1'b0, 1'b0);

        do_op("add_ovf", 1'b0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_cc("add_ovf", 1'b0, 1'b1, 1'b1);

        do_op("and_f0_0f", 1'b1, 4'd2, 64'hF0, 64'h0F, 1'b1, 64'd0, 1'b0);
        check_cc("and_f0_0f", 1'b1, 1'b0, 1'b0);

        do_op("illegal7", 1'b0, 4'd7, 64'd1, 64'd2, 1'b1, 64'd0, 1'b1);
        check_cc("illegal7", 1'b1, 1'b0, 1'b0);

        do_op("xor", 1'b1, 4'd3, 64'hFF00, 64'h0FF0, 1'b0, 64'hF0F0, 1'b0);
        check_cc("xor", 1'b1, 1'b0, 1'b0);

        do_op("sub_neg", 1'b0, 4'd1, 64'd3, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_cc("sub_neg", 1'b0, 1'b1, 1'b0);

        // Both requesters valid, 4 ops each. Last single grant went to req0, so req1 is preferred.
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
`endif
        cnt0 = 0; cnt1 = 0; nresp = 0; cyc = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_fun = 4'd0; req0_a = 64'd0; req0_b = 64'd10; req0_set_cc = 1'b0;
        req1_valid = 1'b1; req1_fun = 4'd1; req1_a = 64'd1; req1_b = 64'd101; req1_set_cc = 1'b0;
        while (nresp < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                e_id  = exp_id_q.pop_front();
                e_res = exp_res_q.pop_front();
                check("burst_rsp_id", W'(rsp_id), W'(e_id));
                check("burst_rsp_result", rsp_result, e_res);
                $display("burst rsp %0d id=%0d result=%h", nresp, rsp_id, rsp_result);
                nresp++;
            end
            if (req0_ready) begin
                grant_ids.push_back(1'b0); exp_id_q.push_back(1'b0);
                exp_res_q.push_back(64'd10 + 64'(cnt0));
                cnt0++;
            end
            if (req1_ready) begin
                grant_ids.push_back(1'b1); exp_id_q.push_back(1'b1);
                exp_res_q.push_back(64'd100 + 64'(cnt1));
                cnt1++;
            end
            @(posedge clk); #1;
            req0_valid = (cnt0 < 4); req0_a = 64'(cnt0);
            req1_valid = (cnt1 < 4); req1_b = 64'd101 + 64'(cnt1);
        end
        check("burst_rsp_count", W'(nresp), W'(8));
        check("burst_grant_count", W'(grant_ids.size()), W'(8));
        for (int k = 0; k < 8 && k < grant_ids.size(); k++)
            check($sformatf("burst_order%0d", k), W'(grant_ids[k]), W'(exp_order[k]));

        // Reset asserted during EXEC: op dropped, CC back to reset values.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_fun = 4'd0; req0_a = 64'd0; req0_b = 64'h8000_0000_0000_0000;
        req0_set_cc = 1'b1;
        @(negedge clk);
        check("rstmid_ready", W'(req0_ready), W'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_rsp_valid", W'(rsp_valid), W'(0));
        check("rstmid_ready0", W'(req0_ready), W'(0));
        check("rstmid_alu_b", alu_b, '0);
        check_cc("rstmid", 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstmid_no_pulse", W'(rsp_valid), W'(0));
        end
        $display("reset mid-op: rsp_valid=%0d cc=%0d%0d%0d", rsp_valid, cc_zf, cc_sf, cc_of);

        do_op("post_rst", 1'b1, 4'd0, 64'd2, 64'd3, 1'b1, 64'd5, 1'b0);
        check_cc("post_rst", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational execute-stage ALU (add/sub/and/xor, 64-bit) between two requesters: req0 = execute stage (OPq/IRMOVQ/etc.), req1 = stack-pointer/address adjust (push/pop/call/ret).
- Round-robin arbitration.
- Drives ALU operands and function, registers the result, returns it tagged with the requester id.
- Owns the Y86 condition-code register (ZF/SF/OF).

Parameters:
- WIDTH, 64, operand/result width.
- FUN_W, 4, ifun field width (Y86 ifun encoding).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_fun  in  FUN_W  ALU function: 0 add, 1 sub, 2 and, 3 xor.
- req0_a, req0_b  in  WIDTH  operands (result = b op a, Y86 convention).
- req0_set_cc  in  1  update CC from this op.
- req1_valid / req1_ready / req1_fun / req1_a / req1_b / req1_set_cc  same as req0 for requester 1.
- alu_a, alu_b  out  WIDTH  to external ALU.
- alu_fun  out  FUN_W  to external ALU.
- alu_y  in  WIDTH  ALU result (combinational).
- alu_of  in  1  ALU signed overflow.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  requester of the result.
- rsp_result  out  WIDTH  registered result.
- rsp_err  out  1  illegal fun (>3).
- cc_zf, cc_sf, cc_of  out  1 each  condition codes.

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; all ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0; alu_a=alu_b=0, alu_fun=0; cc_zf=1, cc_sf=0, cc_of=0; rr pointer=0 (req0 preferred first).
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - If any valid, grant one: a single valid wins; if both valid, the pointer side wins.
  - Assert that side's reqN_ready for exactly that cycle and latch fun/a/b/set_cc/id into operand registers.
  - Go to EXEC. Pointer flips to the non-granted side.
  - ready is combinational from valid in IDLE only; never asserted in EXEC/RESP.
- EXEC:
  - alu_a/alu_b/alu_fun driven from operand registers (held stable whole state; zero/0 in other states).
  - At end of cycle capture alu_y into rsp_result and alu_of into of_tmp.
  - If latched fun>3: rsp_result=0, rsp_err=1, CC untouched. Otherwise rsp_err=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_id/rsp_result/rsp_err.
  - If set_cc and fun legal, at this edge: cc_zf = (result==0), cc_sf = result[WIDTH-1], cc_of = of_tmp (of_tmp forced 0 for and/xor).
  - Next state IDLE. No backpressure on rsp.
- Latency/throughput:
  - Grant at cycle N; rsp_valid at N+2; CC visible at N+3.
  - Max one op per 3 cycles.
- rsp_result, rsp_id, rsp_err hold their last values after the RESP pulse until the next capture.
- Requester valid may drop while not granted (no penalty). Operands are only sampled at the grant cycle.
- Both requesters continuously valid: grants alternate 0,1,0,1...
- Reset mid-operation: op discarded, no rsp pulse, CC returns to reset values.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req0 always wins ties, rr pointer removed (req1 may starve).
- Undefined (default): round-robin as above.

Decomposition:
- Shared package (alu_pkg):
  - ALU fun constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_XOR=3.
  - FSM state enum (IDLE/EXEC/RESP).
  - WIDTH default 64.
- Sub-module alu_rr_arb2: 2-way grant logic plus pointer register, with the fixed-priority variant selected by the macro.
- CC register kept inline.

Test Plan:
- Reset: rst_n low mid-EXEC -> no rsp pulse; cc_zf=1, sf=0, of=0; ready=0.
- req0 only, fun=0, a=5, b=7, set_cc=1 -> ready at N; rsp_valid at N+2, id=0, result=12; CC at N+3: zf=0, sf=0, of=0.
- req1 only, fun=1, a=8, b=8, set_cc=0 -> result=0, id=1; CC unchanged from prior values.
- Both valid continuously, 4 ops each -> grant order 0,1,0,1,...; with ALU_ARB_FIXED_PRIO_EN -> all 4 req0 ops first, then req1.
- Add overflow: a=b=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 -> result 0xFFFF_FFFF_FFFF_FFFE; sf=1, of=1, zf=0. Then and with a=0xF0, b=0x0F -> result=0, zf=1, of=0.
- Illegal fun=7, set_cc=1 -> rsp_err=1, result=0; CC unchanged.
